// File: rtl/memory_stage.sv
// Memory pipeline stage: LOAD/STORE via req/ready handshake with upstream stall,
// all other instructions pass through one register stage to write-back.
module memory_stage #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter logic [4:0]  OP_LOAD  = 5'b01100,
  parameter logic [4:0]  OP_STORE = 5'b01110
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [4:0]        control_in,
  input  logic [4:0]        dest_index_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic              reg_write_en_in,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              valid_out,
  output logic [4:0]        control_out,
  output logic [4:0]        dest_index_out,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_en
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t            state_q;
  state_t            state_d;
  logic              is_mem;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [4:0]        lat_ctrl;
  logic [4:0]        lat_dest;
  logic              lat_wen;

  assign is_mem = valid_in & ((control_in == OP_LOAD) | (control_in == OP_STORE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_mem)    state_d = ACCESS;
      ACCESS:  if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; gated by rst_n so reset forces them low without a clock edge
  always_comb begin
    stall   = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      IDLE:    stall = is_mem;
      ACCESS: begin
        mem_req = 1'b1;
        stall   = ~mem_ready;
      end
      default: ;
    endcase
    stall   = stall & rst_n;
    mem_req = mem_req & rst_n;
  end

  assign mem_we    = lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  // Access latch and write-back register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we         <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      lat_ctrl       <= '0;
      lat_dest       <= '0;
      lat_wen        <= 1'b0;
      valid_out      <= 1'b0;
      control_out    <= '0;
      dest_index_out <= '0;
      wb_data        <= '0;
      wb_en          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_mem) begin
            lat_we    <= (control_in == OP_STORE);
            lat_addr  <= result_in[ADDR_W-1:0];
            lat_wdata <= store_data_in;
            lat_ctrl  <= control_in;
            lat_dest  <= dest_index_in;
            lat_wen   <= reg_write_en_in;
            valid_out <= 1'b0;
            wb_en     <= 1'b0;
          end else if (valid_in) begin
            valid_out      <= 1'b1;
            control_out    <= control_in;
            dest_index_out <= dest_index_in;
            wb_data        <= result_in;
            wb_en          <= reg_write_en_in;
          end else begin
            valid_out <= 1'b0;
            wb_en     <= 1'b0;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            valid_out      <= 1'b1;
            control_out    <= lat_ctrl;
            dest_index_out <= lat_dest;
            wb_data        <= lat_we ? DATA_W'(lat_addr) : mem_rdata;
            wb_en          <= lat_we ? 1'b0 : lat_wen;
          end else begin
            valid_out <= 1'b0;
            wb_en     <= 1'b0;
          end
        end
        default: begin
          valid_out <= 1'b0;
          wb_en     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with an expected-result queue for write-back slots.
module tb_memory_stage;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [4:0]  dest;
    logic [15:0] data;
    logic        en;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [4:0]  control_in;
  logic [4:0]  dest_index_in;
  logic [15:0] result_in;
  logic [15:0] store_data_in;
  logic        reg_write_en_in;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        valid_out;
  logic [4:0]  control_out;
  logic [4:0]  dest_index_out;
  logic [15:0] wb_data;
  logic        wb_en;

  int  checks = 0;
  int  errors = 0;
  wb_t exp_q[$];

  memory_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .control_in(control_in),
    .dest_index_in(dest_index_in), .result_in(result_in), .store_data_in(store_data_in),
    .reg_write_en_in(reg_write_en_in), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .valid_out(valid_out), .control_out(control_out), .dest_index_out(dest_index_out),
    .wb_data(wb_data), .wb_en(wb_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] c, input logic [4:0] d,
                       input logic [15:0] r, input logic [15:0] s, input logic w);
    valid_in = v; control_in = c; dest_index_in = d;
    result_in = r; store_data_in = s; reg_write_en_in = w;
  endtask

  // Advance one edge; a write-back slot must appear exactly when one is expected
  task automatic tick(input string tag);
    wb_t e;
    @(posedge clk);
    #1;
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(exp_q.size() > 0));
    if (valid_out && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".control_out"}, 32'(control_out), 32'(e.ctrl));
      chk({tag, ".dest_index_out"}, 32'(dest_index_out), 32'(e.dest));
      chk({tag, ".wb_data"}, 32'(wb_data), 32'(e.data));
      chk({tag, ".wb_en"}, 32'(wb_en), 32'(e.en));
    end
  endtask

  initial begin
    // Reset with arbitrary (memory-op) inputs
    rst_n = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hDEAD;
    drive(1'b1, 5'h0C, 5'd7, 16'h5555, 16'hAAAA, 1'b1);
    #12;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", 32'(mem_addr), 32'd0);
    chk("rst.mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst.valid_out", 32'(valid_out), 32'd0);
    chk("rst.control_out", 32'(control_out), 32'd0);
    chk("rst.dest_index_out", 32'(dest_index_out), 32'd0);
    chk("rst.wb_data", 32'(wb_data), 32'd0);
    chk("rst.wb_en", 32'(wb_en), 32'd0);
    drive(1'b0, 5'h00, 5'd0, 16'h0, 16'h0, 1'b0);
    mem_ready = 1'b0;
    #1 rst_n = 1'b1;
    tick("idle0");
    tick("idle1");

    // ADD passthrough
    drive(1'b1, 5'h02, 5'd2, 16'd15, 16'h0, 1'b1);
    #1;
    chk("add.stall", 32'(stall), 32'd0);
    chk("add.mem_req", 32'(mem_req), 32'd0);
    exp_q.push_back('{ctrl: 5'h02, dest: 5'd2, data: 16'd15, en: 1'b1});
    tick("add");
    drive(1'b0, 5'h00, 5'd0, 16'h0, 16'h0, 1'b0);
    tick("add.bubble");

    // LOAD with two wait states; mem_ready ignored in IDLE
    mem_ready = 1'b1;
    drive(1'b1, 5'h0C, 5'd3, 16'h0040, 16'h0, 1'b1);
    #1;
    chk("ld.idle.stall", 32'(stall), 32'd1);
    chk("ld.idle.mem_req", 32'(mem_req), 32'd0);
    tick("ld.accept");
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("ld.wait.stall", 32'(stall), 32'd1);
      chk("ld.wait.mem_req", 32'(mem_req), 32'd1);
      chk("ld.wait.mem_addr", 32'(mem_addr), 32'h0040);
      chk("ld.wait.mem_we", 32'(mem_we), 32'd0);
      tick("ld.wait");
    end
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    #1;
    chk("ld.ready.stall", 32'(stall), 32'd0);
    chk("ld.ready.mem_req", 32'(mem_req), 32'd1);
    chk("ld.ready.mem_addr", 32'(mem_addr), 32'h0040);
    exp_q.push_back('{ctrl: 5'h0C, dest: 5'd3, data: 16'hBEEF, en: 1'b1});
    tick("ld.done");
    drive(1'b0, 5'h00, 5'd0, 16'h0, 16'h0, 1'b0);
    mem_ready = 1'b0; mem_rdata = 16'h0;
    #1;
    chk("ld.after.mem_req", 32'(mem_req), 32'd0);
    tick("ld.bubble");

    // STORE zero-wait
    drive(1'b1, 5'h0E, 5'd0, 16'h0010, 16'h1234, 1'b0);
    #1;
    chk("st.idle.stall", 32'(stall), 32'd1);
    tick("st.accept");
    mem_ready = 1'b1;
    #1;
    chk("st.mem_req", 32'(mem_req), 32'd1);
    chk("st.mem_we", 32'(mem_we), 32'd1);
    chk("st.mem_addr", 32'(mem_addr), 32'h0010);
    chk("st.mem_wdata", 32'(mem_wdata), 32'h1234);
    chk("st.stall", 32'(stall), 32'd0);
    exp_q.push_back('{ctrl: 5'h0E, dest: 5'd0, data: 16'h0010, en: 1'b0});
    tick("st.done");
    drive(1'b0, 5'h00, 5'd0, 16'h0, 16'h0, 1'b0);
    mem_ready = 1'b0;
    #1;
    chk("st.after.mem_req", 32'(mem_req), 32'd0);
    tick("st.bubble");

    // Back-to-back: LOAD with one wait, then ADD presented the cycle after completion
    drive(1'b1, 5'h0C, 5'd5, 16'h0080, 16'h0, 1'b1);
    tick("b2b.ld.accept");
    tick("b2b.ld.wait");
    mem_ready = 1'b1; mem_rdata = 16'hCAFE;
    #1;
    chk("b2b.ready.stall", 32'(stall), 32'd0);
    exp_q.push_back('{ctrl: 5'h0C, dest: 5'd5, data: 16'hCAFE, en: 1'b1});
    tick("b2b.ld.done");
    mem_ready = 1'b0;
    drive(1'b1, 5'h02, 5'd6, 16'h0007, 16'h0, 1'b1);
    #1;
    chk("b2b.add.stall", 32'(stall), 32'd0);
    exp_q.push_back('{ctrl: 5'h02, dest: 5'd6, data: 16'h0007, en: 1'b1});
    tick("b2b.add");
    drive(1'b0, 5'h00, 5'd0, 16'h0, 16'h0, 1'b0);
    tick("b2b.bubble");

    // Reset mid-access drops mem_req without a clock edge
    drive(1'b1, 5'h0C, 5'd9, 16'h00F0, 16'h0, 1'b1);
    tick("rma.accept");
    #1;
    chk("rma.mem_req.before", 32'(mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rma.mem_req.async", 32'(mem_req), 32'd0);
    chk("rma.stall.async", 32'(stall), 32'd0);
    drive(1'b0, 5'h00, 5'd0, 16'h0, 16'h0, 1'b0);
    mem_ready = 1'b1; mem_rdata = 16'h9999;
    #1 rst_n = 1'b1;
    tick("rma.post0");
    tick("rma.post1");
    mem_ready = 1'b0;
    drive(1'b1, 5'h02, 5'd1, 16'h0123, 16'h0, 1'b1);
    #1;
    chk("rma.idle.stall", 32'(stall), 32'd0);
    chk("rma.idle.mem_req", 32'(mem_req), 32'd0);
    exp_q.push_back('{ctrl: 5'h02, dest: 5'd1, data: 16'h0123, en: 1'b1});
    tick("rma.add");
    drive(1'b0, 5'h00, 5'd0, 16'h0, 16'h0, 1'b0);
    tick("rma.bubble");

    chk("scoreboard.empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the Execute stage in the 16-bit pipelined core.
- Consumes Execute's registered outputs (control, destination index, ALU result, store data, write enable).
- Performs LOAD/STORE accesses to data memory through a req/ready handshake and stalls upstream while an access is in flight.
- Passes all other instructions through one register stage to write-back.

Parameters:
DATA_W, 16, width of data path and memory data.
ADDR_W, 16, memory address width; mem_addr = result_in[ADDR_W-1:0].
OP_LOAD, 5'b01100, control code for LOAD.
OP_STORE, 5'b01110, control code for STORE.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
valid_in  in  1  Execute presents a valid instruction this cycle.
control_in  in  5  opcode from Execute (control_out).
dest_index_in  in  5  destination register index from Execute.
result_in  in  DATA_W  ALU result; memory address for LOAD/STORE.
store_data_in  in  DATA_W  STORE data (Execute output_reg).
reg_write_en_in  in  1  Execute DEST_REG_WRITE_EN.
stall  out  1  combinational; upstream holds all inputs while high.
mem_req  out  1  memory request.
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
mem_addr  out  ADDR_W  access address.
mem_wdata  out  DATA_W  write data.
mem_ready  in  1  memory completes the request this cycle; for reads, mem_rdata is valid.
mem_rdata  in  DATA_W  read data.
valid_out  out  1  registered; write-back slot holds a valid instruction.
control_out  out  5  registered opcode.
dest_index_out  out  5  registered destination index.
wb_data  out  DATA_W  registered write-back data.
wb_en  out  1  registered register-file write enable.

Behaviour:
- FSM states: IDLE, ACCESS. Reset state is IDLE.
- Reset values: all registered outputs 0; mem_req, mem_we, mem_addr, mem_wdata 0; stall 0.
- Reset asserted mid-ACCESS drops mem_req immediately, without waiting for a clock edge, and discards the access.
- is_mem = valid_in & (control_in == OP_LOAD | control_in == OP_STORE).
- IDLE, valid_in=0: next edge loads a bubble (valid_out=0, wb_en=0, other outputs hold).
- IDLE, valid_in=1, !is_mem: next edge registers valid_out=1, control_out, dest_index_out, wb_data=result_in, wb_en=reg_write_en_in. stall=0. Latency 1 cycle. LOADI, MOV, ALU ops and jumps all take this path.
- IDLE, is_mem:
  - stall=1 in this cycle.
  - Next edge latches addr, we (1 for STORE), wdata, control, dest index and reg_write_en, and moves to ACCESS.
  - Same edge loads a bubble into the output register.
- ACCESS:
  - mem_req=1; mem_addr, mem_we, mem_wdata held stable until completion.
  - stall = !mem_ready.
  - mem_ready=0: stay in ACCESS; output register holds the bubble.
  - mem_ready=1: next edge registers valid_out=1 and moves to IDLE. LOAD sets wb_data=mem_rdata, wb_en=latched reg_write_en. STORE sets wb_en=0 and wb_data=latched address.
  - Upstream advances on this same edge (stall is already low), so the held instruction is never accepted twice.
- Memory op minimum latency: 2 cycles from acceptance to valid_out. Each wait cycle adds 1.
- mem_ready is ignored in IDLE. mem_rdata is sampled only when mem_ready=1 in ACCESS.
- Back-to-back memory ops: the second is seen in IDLE on the cycle after completion; there is no dead cycle beyond its own IDLE cycle.
- Widths: no arithmetic in this stage; address truncated to ADDR_W, data passed unmodified.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> all outputs 0, stall=0; after release with valid_in=0, valid_out stays 0.
- ADD passthrough: valid_in=1, control_in=5'h02, result_in=15, dest_index_in=2, reg_write_en_in=1 -> next edge valid_out=1, wb_data=15, wb_en=1, dest_index_out=2; stall and mem_req stay 0.
- LOAD with wait states: control_in=5'h0C, result_in=16'h0040, dest=3, reg_write_en_in=1; mem_ready low for 2 ACCESS cycles, then high with mem_rdata=16'hBEEF -> stall high for 3 cycles then low in the ready cycle; mem_req high for 3 cycles with mem_addr=16'h0040, mem_we=0; then valid_out=1, wb_data=16'hBEEF, wb_en=1, dest_index_out=3.
- STORE zero-wait: control_in=5'h0E, result_in=16'h0010, store_data_in=16'h1234; mem_ready high in the first ACCESS cycle -> mem_req high exactly 1 cycle with mem_we=1, mem_wdata=16'h1234; then valid_out=1, wb_en=0.
- Back-to-back: LOAD (1 wait cycle) followed by ADD held under stall -> ADD result appears exactly 1 cycle after the LOAD result; neither instruction is duplicated or dropped.
- Reset mid-access: rst_n=0 while in ACCESS with mem_req=1 -> mem_req falls without a clock edge; after release, state is IDLE and no valid_out is produced for the aborted LOAD.
